bus_arbiter: RTL and testbench

- Central interconnect and scheduler for the shared message bus. Sits between the per-core bus adapters.
- Each cycle it picks at most one requesting adapter in round-robin order and acks it.
- It latches the granted message into a single delivery register and presents that message to the destination adapter until the destination accepts it.
- It stamps the sender index as the source address seen by the receiver.

---
 rtl/xctcmsg_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/bus_arbiter.sv | 117 +++++++++++
 tb/tb_bus_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xctcmsg_pkg.sv
// Shared message-bus types: node address, tag, payload and the delivery
// register layout used by the bus arbiter.
package xctcmsg_pkg;

    localparam int BUS_N_NODES = 4;
    localparam int BUS_ADDR_W  = $clog2(BUS_N_NODES);
    localparam int BUS_TAG_W   = 8;
    localparam int BUS_DATA_W  = 64;

    typedef logic [BUS_ADDR_W-1:0] bus_node_addr_t;
    typedef logic [BUS_TAG_W-1:0]  bus_tag_t;
    typedef logic [BUS_DATA_W-1:0] bus_msg_t;

    typedef struct packed {
        bus_node_addr_t src;
        bus_node_addr_t dst;
        bus_tag_t       tag;
        bus_msg_t       msg;
    } bus_delivery_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping
// modulo N. The pointer itself is owned by the caller.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    int               pos;
    logic [IDX_W-1:0] idx;

    // Scan from the farthest slot back to ptr so the nearest requester wins last.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        pos     = 0;
        idx     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            idx = IDX_W'(pos);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Shared message bus: round-robin grant of one sender per cycle into a single
// delivery register that is held until the destination node accepts it.
module bus_arbiter
    import xctcmsg_pkg::*;
#(
    parameter int N_NODES = BUS_N_NODES,
    parameter int ADDR_W  = $clog2(N_NODES),
    parameter int TAG_W   = BUS_TAG_W,
    parameter int DATA_W  = BUS_DATA_W,
    parameter int CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_NODES-1:0]          node_val_i,
    input  logic [N_NODES*ADDR_W-1:0]   node_dst_i,
    input  logic [N_NODES*TAG_W-1:0]    node_tag_i,
    input  logic [N_NODES*DATA_W-1:0]   node_msg_i,
    output logic [N_NODES-1:0]          node_ack_o,
    output logic [N_NODES-1:0]          node_val_o,
    output logic [ADDR_W-1:0]           node_src_o,
    output logic [TAG_W-1:0]            node_tag_o,
    output logic [DATA_W-1:0]           node_msg_o,
    input  logic [N_NODES-1:0]          node_rdy_i,
    output logic [CNT_W-1:0]            drop_count_o
);

    localparam int                N_PAD = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   N_LIM = (ADDR_W + 1)'(N_NODES);

    // Same field order as bus_delivery_t, sized for this instance.
    typedef struct packed {
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dst;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] msg;
    } delivery_t;

    logic [ADDR_W-1:0] dst_arr [N_NODES];
    logic [TAG_W-1:0]  tag_arr [N_NODES];
    logic [DATA_W-1:0] msg_arr [N_NODES];

    generate
        for (genvar gi = 0; gi < N_NODES; gi++) begin : g_unpack
            assign dst_arr[gi] = node_dst_i[gi*ADDR_W +: ADDR_W];
            assign tag_arr[gi] = node_tag_i[gi*TAG_W +: TAG_W];
            assign msg_arr[gi] = node_msg_i[gi*DATA_W +: DATA_W];
        end
    endgenerate

    delivery_t         dlv_q;
    logic              dv_q;
    logic [ADDR_W-1:0] rr_ptr_q;
    logic [CNT_W-1:0]  drop_q;

    logic [N_PAD-1:0]   rdy_pad;
    logic               drain;
    logic               cap_ok;
    logic [N_NODES-1:0] gnt;
    logic [ADDR_W-1:0]  gnt_idx;
    logic               req_any;
    logic               grant;
    logic [ADDR_W-1:0]  win_dst;
    logic               dst_ok;
    logic [ADDR_W-1:0]  ptr_next;

    // Padding keeps the ready lookup in range for non-power-of-two node counts.
    assign rdy_pad = N_PAD'(node_rdy_i);
    assign drain   = dv_q & rdy_pad[dlv_q.dst];
    assign cap_ok  = ~dv_q | drain;

    rr_arbiter #(
        .N     (N_NODES),
        .IDX_W (ADDR_W)
    ) u_rr_arbiter (
        .req     (node_val_i),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (req_any)
    );

    assign grant    = cap_ok & req_any;
    assign win_dst  = dst_arr[gnt_idx];
    assign dst_ok   = {1'b0, win_dst} < N_LIM;
    assign ptr_next = (gnt_idx == ADDR_W'(N_NODES - 1)) ? '0 : gnt_idx + 1'b1;

    // Ack is suppressed while reset is held so senders keep their message.
    assign node_ack_o = (grant & rst_n) ? gnt : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_q     <= 1'b0;
            dlv_q    <= '0;
            rr_ptr_q <= '0;
            drop_q   <= '0;
        end else begin
            if (grant) begin
                rr_ptr_q <= ptr_next;
                dlv_q    <= '{src: gnt_idx, dst: win_dst,
                              tag: tag_arr[gnt_idx], msg: msg_arr[gnt_idx]};
                dv_q     <= dst_ok;
                if (!dst_ok && !(&drop_q)) begin
                    drop_q <= drop_q + 1'b1;
                end
            end else if (drain) begin
                dv_q <= 1'b0;
            end
        end
    end

    assign node_val_o   = dv_q ? (N_NODES'(1) << dlv_q.dst) : '0;
    assign node_src_o   = dlv_q.src;
    assign node_tag_o   = dlv_q.tag;
    assign node_msg_o   = dlv_q.msg;
    assign drop_count_o = drop_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: vector table, hand sequences (drop, saturation,
// reset mid-flight) and randomized traffic against a transaction-level model.
module tb_bus_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 4-node instance
    logic [3:0]   val4, rdy4, ack4, valo4;
    logic [7:0]   dst4;
    logic [31:0]  tag4;
    logic [255:0] msg4;
    logic [1:0]   src4;
    logic [7:0]   tago4;
    logic [63:0]  msgo4;
    logic [15:0]  drop4;

    // 3-node instance with a narrow drop counter to reach saturation quickly
    logic [2:0]   val3, rdy3, ack3, valo3;
    logic [5:0]   dst3;
    logic [23:0]  tag3;
    logic [191:0] msg3;
    logic [1:0]   src3;
    logic [7:0]   tago3;
    logic [63:0]  msgo3;
    logic [1:0]   drop3;

    bus_arbiter #(.N_NODES(4), .CNT_W(16)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .node_val_i(val4), .node_dst_i(dst4), .node_tag_i(tag4), .node_msg_i(msg4),
        .node_ack_o(ack4), .node_val_o(valo4), .node_src_o(src4),
        .node_tag_o(tago4), .node_msg_o(msgo4), .node_rdy_i(rdy4),
        .drop_count_o(drop4)
    );

    bus_arbiter #(.N_NODES(3), .CNT_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .node_val_i(val3), .node_dst_i(dst3), .node_tag_i(tag3), .node_msg_i(msg3),
        .node_ack_o(ack3), .node_val_o(valo3), .node_src_o(src3),
        .node_tag_o(tago3), .node_msg_o(msgo3), .node_rdy_i(rdy3),
        .drop_count_o(drop3)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] val;
        logic [7:0] dst;
        logic [3:0] rdy;
        logic [3:0] ack;
        logic [3:0] valo;
        logic [1:0] src;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] v, input logic [7:0] d, input logic [3:0] r,
                                input logic [3:0] a, input logic [3:0] vo, input logic [1:0] s);
        vec_t x;
        x.val = v; x.dst = d; x.rdy = r; x.ack = a; x.valo = vo; x.src = s;
        return x;
    endfunction

    logic [7:0]  kt [4] = '{8'h50, 8'h5A, 8'h52, 8'h53};
    logic [63:0] km [4] = '{64'hBEEF0000, 64'hDEAD, 64'hC0DE0002, 64'hF00D0003};

    vec_t vecs[$];

    // Reference model state for random traffic
    int m_dv, m_ptr, m_src, m_dst, win;
    logic [7:0]  m_tag;
    logic [63:0] m_msg;
    logic        free;
    logic [3:0]  exp_ack, exp_valo;

    initial begin
        rst_n = 1'b0;
        val4 = 4'hF; dst4 = '0; rdy4 = 4'hF; tag4 = '0; msg4 = '0;
        val3 = 3'b111; dst3 = '0; rdy3 = 3'b111; tag3 = '0; msg3 = '0;
        for (int i = 0; i < 4; i++) begin
            tag4[i*8 +: 8]   = kt[i];
            msg4[i*64 +: 64] = km[i];
        end

        // Reset state with requests pending: no ack, no delivery
        @(negedge clk); @(negedge clk);
        chk("reset ack4", 64'(ack4), 64'h0);
        chk("reset valo4", 64'(valo4), 64'h0);
        chk("reset drop4", 64'(drop4), 64'h0);
        chk("reset ack3", 64'(ack3), 64'h0);
        chk("reset drop3", 64'(drop3), 64'h0);
        val4 = '0; val3 = '0;
        rst_n = 1'b1;

        // Single send, round-robin, back-pressure, loopback
        vecs.push_back(mk(4'b0010, 8'h08, 4'hF, 4'b0010, 4'b0000, 2'd0));
        vecs.push_back(mk(4'b0000, 8'h00, 4'hF, 4'b0000, 4'b0100, 2'd1));
        vecs.push_back(mk(4'b0000, 8'h00, 4'hF, 4'b0000, 4'b0000, 2'd0));
        vecs.push_back(mk(4'b1111, 8'h00, 4'hF, 4'b0100, 4'b0000, 2'd0));
        vecs.push_back(mk(4'b1111, 8'h00, 4'hF, 4'b1000, 4'b0001, 2'd2));
        vecs.push_back(mk(4'b1111, 8'h00, 4'hF, 4'b0001, 4'b0001, 2'd3));
        vecs.push_back(mk(4'b1111, 8'h00, 4'hF, 4'b0010, 4'b0001, 2'd0));
        vecs.push_back(mk(4'b1111, 8'h00, 4'hF, 4'b0100, 4'b0001, 2'd1));
        vecs.push_back(mk(4'b0000, 8'h00, 4'hF, 4'b0000, 4'b0001, 2'd2));
        vecs.push_back(mk(4'b0000, 8'h00, 4'hF, 4'b0000, 4'b0000, 2'd0));
        vecs.push_back(mk(4'b0001, 8'h03, 4'hF, 4'b0001, 4'b0000, 2'd0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(4'b0100, 8'h10, 4'b0111, 4'b0000, 4'b1000, 2'd0));
        vecs.push_back(mk(4'b0100, 8'h10, 4'hF, 4'b0100, 4'b1000, 2'd0));
        vecs.push_back(mk(4'b0000, 8'h00, 4'hF, 4'b0000, 4'b0010, 2'd2));
        vecs.push_back(mk(4'b1000, 8'hC0, 4'hF, 4'b1000, 4'b0000, 2'd0));
        vecs.push_back(mk(4'b0000, 8'h00, 4'hF, 4'b0000, 4'b1000, 2'd3));
        vecs.push_back(mk(4'b0000, 8'h00, 4'hF, 4'b0000, 4'b0000, 2'd0));

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            val4 = vecs[i].val; dst4 = vecs[i].dst; rdy4 = vecs[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d ack", i), 64'(ack4), 64'(vecs[i].ack));
            chk($sformatf("vec%0d valo", i), 64'(valo4), 64'(vecs[i].valo));
            if (vecs[i].valo != 4'b0000) begin
                chk($sformatf("vec%0d src", i), 64'(src4), 64'(vecs[i].src));
                chk($sformatf("vec%0d tag", i), 64'(tago4), 64'(kt[vecs[i].src]));
                chk($sformatf("vec%0d msg", i), msgo4, km[vecs[i].src]);
            end
        end
        @(posedge clk); #1;
        val4 = '0;

        // Drop path on the 3-node instance: dst 3 does not exist
        tag3[15:8] = 8'h77; msg3[127:64] = 64'h1234;
        val3 = 3'b001; dst3 = 6'b001011; rdy3 = 3'b111;
        @(negedge clk);
        chk("drop c1 ack", 64'(ack3), 64'h1);
        chk("drop c1 cnt", 64'(drop3), 64'h0);
        @(posedge clk); #1; val3 = 3'b010;
        @(negedge clk);
        chk("drop c2 ack", 64'(ack3), 64'h2);
        chk("drop c2 valo", 64'(valo3), 64'h0);
        chk("drop c2 cnt", 64'(drop3), 64'h1);
        @(posedge clk); #1; val3 = 3'b001;
        @(negedge clk);
        chk("drop c3 ack", 64'(ack3), 64'h1);
        chk("drop c3 valo", 64'(valo3), 64'h4);
        chk("drop c3 src", 64'(src3), 64'h1);
        chk("drop c3 tag", 64'(tago3), 64'h77);
        chk("drop c3 msg", msgo3, 64'h1234);
        @(posedge clk); #1;
        @(negedge clk);
        chk("drop c4 ack", 64'(ack3), 64'h1);
        chk("drop c4 valo", 64'(valo3), 64'h0);
        chk("drop c4 cnt", 64'(drop3), 64'h2);
        @(posedge clk); #1;
        @(negedge clk);
        chk("drop c5 cnt", 64'(drop3), 64'h3);
        @(posedge clk); #1;
        @(negedge clk);
        chk("drop c6 sat", 64'(drop3), 64'h3);
        @(posedge clk); #1; val3 = 3'b000;
        @(negedge clk);
        chk("drop c7 sat", 64'(drop3), 64'h3);
        chk("drop c7 valo", 64'(valo3), 64'h0);

        // Reset while a message is stalled and others are waiting
        @(posedge clk); #1;
        val4 = 4'b0001; dst4 = 8'h03; rdy4 = 4'b0111;
        @(negedge clk);
        chk("rst ack pre", 64'(ack4), 64'h1);
        @(posedge clk); #1;
        val4 = 4'b0110; dst4 = 8'h00;
        @(negedge clk);
        chk("rst stall valo", 64'(valo4), 64'h8);
        chk("rst stall ack", 64'(ack4), 64'h0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst async valo", 64'(valo4), 64'h0);
        chk("rst async ack", 64'(ack4), 64'h0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst first grant", 64'(ack4), 64'h2);

        // Clean reset before random traffic
        @(posedge clk); #1;
        val4 = '0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_dv = 0; m_ptr = 0; m_src = 0; m_dst = 0; m_tag = '0; m_msg = '0;

        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            val4 = 4'($urandom);
            dst4 = 8'($urandom);
            rdy4 = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                tag4[i*8 +: 8]   = 8'($urandom);
                msg4[i*64 +: 64] = {$urandom, $urandom};
            end
            @(negedge clk);
            exp_valo = (m_dv != 0) ? 4'(1 << m_dst) : 4'b0000;
            chk($sformatf("rnd%0d valo", c), 64'(valo4), 64'(exp_valo));
            if (m_dv != 0) begin
                chk($sformatf("rnd%0d src", c), 64'(src4), 64'(m_src));
                chk($sformatf("rnd%0d tag", c), 64'(tago4), 64'(m_tag));
                chk($sformatf("rnd%0d msg", c), msgo4, m_msg);
            end
            free = (m_dv == 0) || rdy4[m_dst];
            win = -1;
            if (free) begin
                for (int d = 0; d < 4; d++) begin
                    if (win < 0 && val4[(m_ptr + d) % 4]) win = (m_ptr + d) % 4;
                end
            end
            exp_ack = (win >= 0) ? 4'(1 << win) : 4'b0000;
            chk($sformatf("rnd%0d ack", c), 64'(ack4), 64'(exp_ack));
            if (win >= 0) begin
                m_ptr = (win + 1) % 4;
                m_dv  = 1;
                m_src = win;
                m_dst = int'(dst4[win*2 +: 2]);
                m_tag = tag4[win*8 +: 8];
                m_msg = msg4[win*64 +: 64];
            end else if (free) begin
                m_dv = 0;
            end
        end
        chk("rnd drop4", 64'(drop4), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
